// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the console UART transmitter.
//   tx_state_e      : transmitter FSM states (PARITY only exists when the
//                     UART_TX_PARITY_EN macro is defined)
//   UART_DATA_BITS  : data bits per frame
//   UART_IDLE_LEVEL : line level while idle / during the stop bit
//   frame_parity()  : parity bit for a data byte (even, or odd when requested)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_sync_fifo
// Synchronous byte FIFO with first-word-fall-through read: head always shows
// the oldest entry while empty is low, and pop simply advances past it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : byte to store
//   pop        : discard the head entry (ignored when empty)
//   head       : oldest stored byte
//   full/empty : occupancy flags decoded from the registered count
//   level      : registered occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_sync_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];

    // A push while full is refused even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Console UART transmitter: bytes written through a valid/ready handshake are
// queued in a small FIFO and sent as 8N1 frames, LSB first, with a bit time of
// (baud_div_i + 1) clocks. Consecutive frames are sent with no idle gap.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (8E1 / 8O1) and the
// parity_odd_i input.
// Ports:
//   wb_clk_i     : system clock
//   wb_rst_i     : synchronous active-high reset (line idles, FIFO flushed)
//   baud_div_i   : clocks per bit minus 1, captured at each frame start
//   tx_en_i      : permits new frames to start (a running frame always ends)
//   parity_odd_i : (UART_TX_PARITY_EN only) odd parity select, per frame
//   wdata_i      : byte to queue
//   wvalid_i     : write request; accepted when wready_o is high
//   wready_o     : FIFO not full
//   txd_o        : registered serial output, idle high
//   busy_o       : frame in progress or bytes still queued
//   level_o      : FIFO occupancy
//   empty_irq_o  : one-cycle pulse when the last queued frame finishes
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             tx_en_i,
`ifdef UART_TX_PARITY_EN
    input  logic             parity_odd_i,
`endif
    input  logic [7:0]       wdata_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    output logic             txd_o,
    output logic             busy_o,
    output logic [LVL_W-1:0] level_o,
    output logic             empty_irq_o
);

    localparam int BIT_CW = $clog2(UART_DATA_BITS);

    tx_state_e        state;
    tx_state_e        state_d;
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_q;
    logic [BIT_CW-1:0] bit_cnt;
    logic [7:0]       shift_q;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             bit_end;
    logic             last_data_bit;
    logic             txd_d;
    logic             irq_d;

    uart_tx_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (wvalid_i),
        .push_data (wdata_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_o)
    );

    assign wready_o      = !fifo_full;
    assign busy_o        = (state != IDLE) || (level_o != '0);
    assign bit_end       = (baud_cnt == '0);
    assign last_data_bit = (bit_cnt == BIT_CW'(UART_DATA_BITS - 1));

    // State register with the baud and bit counters.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= state_d;
            if (fifo_pop) begin
                // Frame start: the first bit uses the divisor seen right now.
                baud_cnt <= baud_div_i;
                bit_cnt  <= '0;
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? div_q : baud_cnt - 1'b1;
                if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Frame data captured at pop; no reset needed since it is only read
    // after a pop has loaded it.
    always_ff @(posedge wb_clk_i) begin
        if (fifo_pop) begin
            shift_q <= fifo_head;
            div_q   <= baud_div_i;
`ifdef UART_TX_PARITY_EN
            par_q   <= frame_parity(fifo_head, parity_odd_i);
`endif
        end else if (state == DATA && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Next-state logic; also decides when the FIFO head is consumed.
    always_comb begin
        state_d  = state;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en_i && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end && last_data_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when possible.
                    if (tx_en_i && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; registered below, so the line lags the state by a cycle.
    always_comb begin
        txd_d = UART_IDLE_LEVEL;
        case (state)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            STOP:    txd_d = UART_IDLE_LEVEL;
            default: txd_d = UART_IDLE_LEVEL;
        endcase
        // Only when the stop bit ends with nothing left to send; a frame held
        // back by tx_en_i with data still queued does not raise it.
        irq_d = (state == STOP) && bit_end && (state_d == IDLE) && fifo_empty;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            txd_o       <= UART_IDLE_LEVEL;
            empty_irq_o <= 1'b0;
        end else begin
            txd_o       <= txd_d;
            empty_irq_o <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A line monitor decodes every frame on
// txd_o clock by clock; expected frames come from a byte queue of accepted
// writes and the 8N1 (or 8xP1) framing rule.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd15;
    logic        tx_en = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        txd;
    logic        busy;
    logic [3:0]  level;
    logic        irq;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(.FIFO_DEPTH(8), .DIV_W(16), .LVL_W(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .baud_div_i   (baud_div),
        .tx_en_i      (tx_en),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i (parity_odd),
`endif
        .wdata_i      (wdata),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .txd_o        (txd),
        .busy_o       (busy),
        .level_o      (level),
        .empty_irq_o  (irq)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rst_edges = 0;
    int low_cnt = 0;
    int irq_cnt = 0;
    int inv_bad = 0;
    bit inv_en = 1'b0;
    logic [15:0] cur_div = 16'd15;

    typedef struct {
        logic [10:0] line;
        bit          glitch;
        int          start_cyc;
    } rx_t;
    rx_t         rx_q[$];
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        logic [9:0]  line;
    } vec_t;
    vec_t vecs [6];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_edges <= rst_edges + 1;
    end

    // Counters sampled just after the falling edge, so reads at the falling
    // edge always see totals up to the previous one.
    always begin
        @(negedge clk);
        #1;
        if (txd === 1'b0) low_cnt <= low_cnt + 1;
        if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
        if (inv_en && ((wready !== (level != 4'd8)) || (level > 4'd8) ||
                       (level != 4'd0 && busy !== 1'b1)))
            inv_bad <= inv_bad + 1;
    end

    // Line monitor: every bit must hold for exactly cur_div+1 clocks.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                rx_t  r;
                int   bl;
                int   re;
                logic s;
                r.line = '0;
                r.glitch = 1'b0;
                r.start_cyc = cyc;
                bl = int'(cur_div) + 1;
                re = rst_edges;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < bl; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        s = txd;
                        if (c == 0) r.line[b] = s;
                        else if (s !== r.line[b]) r.glitch = 1'b1;
                    end
                end
                if (rst_edges == re) rx_q.push_back(r);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int limit);
        checks++;
        errors++;
        $display("FAIL %s: got no event within %0d cycles, expected event", name, limit);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line pattern, bit i = i-th bit on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic odd);
`ifdef UART_TX_PARITY_EN
        return {1'b1, (^d) ^ odd, d, 1'b0};
`else
        return 11'({1'b1, d, 1'b0});
`endif
    endfunction

    task automatic write_byte(input logic [7:0] d, output int acc_cyc);
        int g;
        g = 0;
        wvalid = 1'b1;
        wdata  = d;
        while (wready !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            bound_fail("write_accept", 5000);
            wvalid = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(negedge clk);
        acc_cyc = cyc;
        exp_q.push_back(d);
        wvalid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int g;
        g = 0;
        while (busy !== 1'b0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (g >= limit) bound_fail("drain", limit);
        tick(3);
    endtask

    task automatic wait_low(input int limit, output bit found);
        int g;
        g = 0;
        while (txd !== 1'b0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        found = (g < limit);
        if (!found) bound_fail("start_bit", limit);
    endtask

    initial begin : main
        int   acc;
        int   i0;
        int   l0;
        bit   found;
        logic [10:0] exp_line;
        logic odd;

        vecs[0] = '{16'd15, 8'h55, 10'b1010101010};
        vecs[1] = '{16'd0,  8'hA5, 10'b1101001010};
        vecs[2] = '{16'd1,  8'h00, 10'b1000000000};
        vecs[3] = '{16'd2,  8'hFF, 10'b1111111110};
        vecs[4] = '{16'd3,  8'h80, 10'b1100000000};
        vecs[5] = '{16'd1,  8'h3C, 10'b1001111000};

        // Reset state
        tick(3);
        check("rst_txd",    32'(txd),    32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_level",  32'(level),  32'd0);
        check("rst_irq",    32'(irq),    32'd0);
        rst = 1'b0;
        tick(2);
        tx_en = 1'b1;

        // Single frames from the vector table; the divisor input is disturbed
        // mid-frame and must not affect the frame in flight.
        for (int v = 0; v < 6; v++) begin
            cur_div  = vecs[v].div;
            baud_div = vecs[v].div;
            rx_q.delete();
            exp_q.delete();
            i0 = irq_cnt;
            write_byte(vecs[v].data, acc);
            tick(2);
            baud_div = 16'd7;
            wait_idle(400);
`ifdef UART_TX_PARITY_EN
            exp_line = {1'b1, (^vecs[v].data) ^ parity_odd, vecs[v].line[8:0]};
`else
            exp_line = {1'b0, vecs[v].line};
`endif
            check($sformatf("vec%0d_frames", v), 32'(rx_q.size()), 32'd1);
            if (rx_q.size() >= 1) begin
                check($sformatf("vec%0d_line", v),    32'(rx_q[0].line),   32'(exp_line));
                check($sformatf("vec%0d_timing", v),  32'(rx_q[0].glitch), 32'd0);
                check($sformatf("vec%0d_latency", v), 32'(rx_q[0].start_cyc - acc), 32'd2);
            end
            check($sformatf("vec%0d_irq", v),   32'(irq_cnt - i0), 32'd1);
            check($sformatf("vec%0d_level", v), 32'(level), 32'd0);
        end

        // Nine back-to-back writes fill the FIFO; a tenth waits for space.
        cur_div  = 16'd15;
        baud_div = 16'd15;
        rx_q.delete();
        exp_q.delete();
        i0 = irq_cnt;
        for (int k = 0; k < 9; k++) write_byte(8'h30 + 8'(k), acc);
        check("full_wready", 32'(wready), 32'd0);
        check("full_level",  32'(level),  32'd8);
        write_byte(8'hEE, acc);
        check("refill_level",  32'(level),  32'd8);
        check("refill_wready", 32'(wready), 32'd0);
        wait_idle(3000);
        check("b2b_frames", 32'(rx_q.size()), 32'd10);
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            check($sformatf("b2b_line%0d", k), 32'(rx_q[k].line), 32'(frame_of(exp_q[k], 1'b0)));
            check($sformatf("b2b_timing%0d", k), 32'(rx_q[k].glitch), 32'd0);
            if (k > 0)
                check($sformatf("b2b_gap%0d", k), 32'(rx_q[k].start_cyc - rx_q[k-1].start_cyc), 32'd160);
        end
        check("b2b_irq", 32'(irq_cnt - i0), 32'd1);

        // Transmit disabled: bytes queue up, line stays idle.
        tx_en = 1'b0;
        rx_q.delete();
        exp_q.delete();
        write_byte(8'h41, acc);
        write_byte(8'h42, acc);
        l0 = low_cnt;
        tick(40);
        check("hold_low_samples", 32'(low_cnt - l0), 32'd0);
        check("hold_level", 32'(level), 32'd2);
        check("hold_busy",  32'(busy),  32'd1);
        check("hold_txd",   32'(txd),   32'd1);
        i0 = irq_cnt;
        tx_en = 1'b1;
        wait_idle(1000);
        check("ab_frames", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("ab_first",  32'(rx_q[0].line[8:1]), 32'h41);
            check("ab_second", 32'(rx_q[1].line[8:1]), 32'h42);
        end
        check("ab_irq", 32'(irq_cnt - i0), 32'd1);

        // Reset during data bit 3 of 0x7E with three more bytes queued.
        tx_en = 1'b0;
        rx_q.delete();
        exp_q.delete();
        write_byte(8'h7E, acc);
        write_byte(8'h11, acc);
        write_byte(8'h22, acc);
        write_byte(8'h33, acc);
        check("pre_rst_level", 32'(level), 32'd4);
        tx_en = 1'b1;
        wait_low(100, found);
        tick(68);
        i0 = irq_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_txd",    32'(txd),    32'd1);
        check("midrst_level",  32'(level),  32'd0);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_wready", 32'(wready), 32'd1);
        l0 = low_cnt;
        tick(300);
        check("midrst_quiet",  32'(low_cnt - l0), 32'd0);
        check("midrst_frames", 32'(rx_q.size()),  32'd0);
        check("midrst_irq",    32'(irq_cnt - i0), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity bit for 0x07 (three ones): even -> 1, odd -> 0.
        cur_div  = 16'd3;
        baud_div = 16'd3;
        for (int p = 0; p < 2; p++) begin
            rx_q.delete();
            parity_odd = p[0];
            write_byte(8'h07, acc);
            wait_idle(400);
            check($sformatf("par%0d_frames", p), 32'(rx_q.size()), 32'd1);
            if (rx_q.size() == 1) begin
                check($sformatf("par%0d_bit", p),  32'(rx_q[0].line[9]), (p == 0) ? 32'd1 : 32'd0);
                check($sformatf("par%0d_line", p), 32'(rx_q[0].line), 32'(frame_of(8'h07, p[0])));
            end
        end
`endif

        // Randomised traffic against the byte-queue model.
        for (int batch = 0; batch < 3; batch++) begin
            cur_div  = 16'($urandom_range(0, 3));
            baud_div = cur_div;
            odd = 1'b0;
`ifdef UART_TX_PARITY_EN
            odd = 1'($urandom_range(0, 1));
            parity_odd = odd;
`endif
            rx_q.delete();
            exp_q.delete();
            inv_bad = 0;
            inv_en = 1'b1;
            for (int it = 0; it < 40; it++) begin
                tx_en = ($urandom_range(0, 4) != 0) || (level == 4'd8);
                if ($urandom_range(0, 1) == 1) write_byte(8'($urandom), acc);
                else tick(1);
            end
            tx_en = 1'b1;
            wait_idle(20000);
            inv_en = 1'b0;
            tick(2);
            check($sformatf("rnd%0d_invariants", batch), 32'(inv_bad), 32'd0);
            check($sformatf("rnd%0d_count", batch), 32'(rx_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
                check($sformatf("rnd%0d_line%0d", batch, k), 32'(rx_q[k].line), 32'(frame_of(exp_q[k], odd)));
                check($sformatf("rnd%0d_timing%0d", batch, k), 32'(rx_q[k].glitch), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
